maxnet_controller: RTL and testbench

MAXNET_CONTROLLER -- requirements
Module: maxnet_controller

---
 rtl/maxnet_pkg.sv | 20 ++
 rtl/maxnet_watchdog.sv | 41 ++++
 rtl/maxnet_controller.sv | 122 ++++++++++++
 tb/tb_maxnet_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// Shared definitions for the MAXNET controller and its datapath.
package maxnet_pkg;

    // Controller state encoding.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD   = 4'd1,
        ST_CLR    = 4'd2,
        ST_START  = 4'd3,
        ST_WAIT   = 4'd4,
        ST_UPDATE = 4'd5,
        ST_CHECK  = 4'd6,
        ST_DONE   = 4'd7,
        ST_FAULT  = 4'd8
    } state_t;

    // IEEE-754 single-precision 1.0, used by the datapath.
    localparam logic [31:0] FP32_ONE = 32'h3F800000;

endpackage

// File: rtl/maxnet_watchdog.sv
// Clearable, saturating counter of cycles spent waiting for the PLUs.
module maxnet_watchdog #(
    parameter int PLU_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    import maxnet_pkg::*;

    localparam int CW = $clog2(PLU_TIMEOUT + 1);
    localparam logic [CW-1:0] CMAX = CW'(PLU_TIMEOUT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Clear wins over increment; the count sticks at its last expiry value.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != CMAX)) begin
            count_d = count_q + ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == CMAX);

endmodule

// File: rtl/maxnet_controller.sv
// Sequencer for one MAXNET competition: load, iterate PLU rounds, detect
// convergence, iteration limit or PLU timeout.
module maxnet_controller #(
    parameter int MAX_ITER    = 16,
    parameter int PLU_TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          go,
    input  logic                          plu_done,
    input  logic                          finish,
    output logic                          rst_plu,
    output logic                          eps_reg_we,
    output logic                          we_prim,
    output logic                          we_a_reg,
    output logic                          mux_sel,
    output logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          fault,
    output logic [$clog2(MAX_ITER+1)-1:0] iter_count
);
    import maxnet_pkg::*;

    localparam int IW = $clog2(MAX_ITER + 1);
    localparam logic [IW-1:0] ITER_MAX = IW'(MAX_ITER);
    localparam logic [IW-1:0] ONE      = IW'(1);

    state_t        state_q, state_d;
    logic [IW-1:0] iter_q, iter_d;
    logic          fault_q, fault_d;
    logic          rst_plu_q, eps_q, prim_q, wea_q, mux_q, start_q, busy_q, done_q;
    logic          wd_expired;

    maxnet_watchdog #(.PLU_TIMEOUT(PLU_TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == ST_START),
        .inc     (state_q == ST_WAIT),
        .expired (wd_expired)
    );

    // Next-state logic; plu_done beats timeout and finish beats the iteration limit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (go) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_CLR;
            ST_CLR:    state_d = ST_START;
            ST_START:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (plu_done)        state_d = ST_UPDATE;
                else if (wd_expired) state_d = ST_FAULT;
            end
            ST_UPDATE: state_d = ST_CHECK;
            ST_CHECK: begin
                if (finish)                  state_d = ST_DONE;
                else if (iter_q == ITER_MAX) state_d = ST_FAULT;
                else                         state_d = ST_CLR;
            end
            ST_DONE:   state_d = ST_IDLE;
            ST_FAULT:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Counter and sticky fault look ahead at the next state so they line up with the strobes.
    always_comb begin
        iter_d  = iter_q;
        fault_d = fault_q;
        if (state_d == ST_LOAD) begin
            iter_d  = '0;
            fault_d = 1'b0;
        end else if ((state_d == ST_UPDATE) && (iter_q != ITER_MAX)) begin
            iter_d = iter_q + ONE;
        end
        if (state_d == ST_FAULT) begin
            fault_d = 1'b1;
        end
    end

    // State, counter and registered strobes decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            iter_q    <= '0;
            fault_q   <= 1'b0;
            rst_plu_q <= 1'b0;
            eps_q     <= 1'b0;
            prim_q    <= 1'b0;
            wea_q     <= 1'b0;
            mux_q     <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            fault_q   <= fault_d;
            rst_plu_q <= (state_d == ST_CLR);
            eps_q     <= (state_d == ST_LOAD);
            prim_q    <= (state_d == ST_LOAD);
            wea_q     <= (state_d == ST_LOAD) || (state_d == ST_UPDATE);
            mux_q     <= (state_d == ST_LOAD);
            start_q   <= (state_d == ST_START);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE) || (state_d == ST_FAULT);
        end
    end

    assign rst_plu    = rst_plu_q;
    assign eps_reg_we = eps_q;
    assign we_prim    = prim_q;
    assign we_a_reg   = wea_q;
    assign mux_sel    = mux_q;
    assign start      = start_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller: instance A (MAX_ITER=16) and
// instance B (MAX_ITER=4), both with PLU_TIMEOUT=8.
module tb_maxnet_controller;

    logic clk = 1'b0;
    logic rst, go_a, go_b, plu_done, finish;

    logic rst_plu_a, eps_a, prim_a, wea_a, mux_a, start_a, busy_a, done_a, fault_a;
    logic rst_plu_b, eps_b, prim_b, wea_b, mux_b, start_b, busy_b, done_b, fault_b;
    logic [4:0] iter_a;
    logic [2:0] iter_b;
    logic [8:0] va, vb;

    int tests  = 0;
    int failed = 0;

    int cnt_start_a = 0, cnt_upd_a = 0, cnt_load_a = 0, cnt_done_a = 0, cnt_done_b = 0;
    int s_start, s_upd, s_load, s_done;

    always #5 clk = ~clk;

    maxnet_controller #(.MAX_ITER(16), .PLU_TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst), .go(go_a), .plu_done(plu_done), .finish(finish),
        .rst_plu(rst_plu_a), .eps_reg_we(eps_a), .we_prim(prim_a), .we_a_reg(wea_a),
        .mux_sel(mux_a), .start(start_a), .busy(busy_a), .done(done_a),
        .fault(fault_a), .iter_count(iter_a)
    );

    maxnet_controller #(.MAX_ITER(4), .PLU_TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst), .go(go_b), .plu_done(plu_done), .finish(finish),
        .rst_plu(rst_plu_b), .eps_reg_we(eps_b), .we_prim(prim_b), .we_a_reg(wea_b),
        .mux_sel(mux_b), .start(start_b), .busy(busy_b), .done(done_b),
        .fault(fault_b), .iter_count(iter_b)
    );

    // Output vector order: rst_plu, eps_reg_we, we_prim, we_a_reg, mux_sel, start, busy, done, fault
    assign va = {rst_plu_a, eps_a, prim_a, wea_a, mux_a, start_a, busy_a, done_a, fault_a};
    assign vb = {rst_plu_b, eps_b, prim_b, wea_b, mux_b, start_b, busy_b, done_b, fault_b};

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (start_a)          cnt_start_a <= cnt_start_a + 1;
        if (wea_a && !mux_a)  cnt_upd_a   <= cnt_upd_a + 1;
        if (mux_a)            cnt_load_a  <= cnt_load_a + 1;
        if (done_a)           cnt_done_a  <= cnt_done_a + 1;
        if (done_b)           cnt_done_b  <= cnt_done_b + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input bit sel);
        int n = 0;
        while (!(sel ? start_b : start_a) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("start_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input bit sel);
        int n = 0;
        while ((sel ? busy_b : busy_a) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // One PLU round: plu_done in WAIT cycle dly, finish presented through CHECK.
    // Returns at the negedge of the state following CHECK.
    task automatic round(input bit sel, input int dly, input bit fin);
        wait_start(sel);
        repeat (dly) @(negedge clk);
        plu_done = 1'b1;
        finish   = fin;
        @(negedge clk);
        plu_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        finish = 1'b0;
    endtask

    task automatic snap();
        #1;
        s_start = cnt_start_a;
        s_upd   = cnt_upd_a;
        s_load  = cnt_load_a;
        s_done  = cnt_done_a;
    endtask

    initial begin
        rst = 1'b1; go_a = 1'b0; go_b = 1'b0; plu_done = 1'b0; finish = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_outs_a", va, 9'b0);
        chk("rst_iter_a", iter_a, 0);
        chk("rst_outs_b", vb, 9'b0);
        rst = 1'b0;
        @(negedge clk);

        // Convergence in one round, cycle by cycle.
        go_a = 1'b1;
        @(negedge clk); go_a = 1'b0;
        chk("t1_load", va, 9'b011110100);
        chk("t1_load_iter", iter_a, 0);
        @(negedge clk); chk("t1_clr", va, 9'b100000100);
        @(negedge clk); chk("t1_start", va, 9'b000001100);
        @(negedge clk); chk("t1_wait1", va, 9'b000000100);
        @(negedge clk); chk("t1_wait2", va, 9'b000000100);
        @(negedge clk); chk("t1_wait3", va, 9'b000000100);
        plu_done = 1'b1; finish = 1'b1;
        @(negedge clk); chk("t1_update", va, 9'b000100100);
        chk("t1_update_iter", iter_a, 1);
        plu_done = 1'b0;
        @(negedge clk); chk("t1_check", va, 9'b000000100);
        @(negedge clk); chk("t1_done", va, 9'b000000110);
        finish = 1'b0;
        @(negedge clk); chk("t1_idle", va, 9'b000000000);
        chk("t1_idle_iter", iter_a, 1);
        @(negedge clk); chk("t1_idle2", va, 9'b000000000);

        // Five rounds, finish only in the fifth.
        snap();
        go_a = 1'b1;
        @(negedge clk); go_a = 1'b0;
        for (int r = 1; r <= 5; r++) round(1'b0, 2, r == 5);
        wait_idle(1'b0);
        #1;
        chk("t2_starts", cnt_start_a - s_start, 5);
        chk("t2_updates", cnt_upd_a - s_upd, 5);
        chk("t2_dones", cnt_done_a - s_done, 1);
        chk("t2_iter", iter_a, 5);
        chk("t2_fault", fault_a, 0);

        // Iteration limit on B: finish never asserted.
        #1; s_done = cnt_done_b;
        go_b = 1'b1;
        @(negedge clk); go_b = 1'b0;
        for (int r = 1; r <= 4; r++) round(1'b1, 1, 1'b0);
        chk("t3_fault_state", vb, 9'b000000111);
        chk("t3_iter", iter_b, 4);
        @(negedge clk);
        chk("t3_idle_sticky", vb, 9'b000000001);
        #1;
        chk("t3_dones", cnt_done_b - s_done, 1);

        // Watchdog on A: plu_done never asserted.
        @(negedge clk);
        go_a = 1'b1;
        @(negedge clk); go_a = 1'b0;
        wait_start(1'b0);
        repeat (8) @(negedge clk);
        chk("t4_wait8", va, 9'b000000100);
        @(negedge clk);
        chk("t4_fault_state", va, 9'b000000111);
        chk("t4_iter", iter_a, 0);
        repeat (3) @(negedge clk);
        chk("t4_fault_held", va, 9'b000000001);

        // plu_done on the expiry cycle; LOAD clears the sticky fault.
        go_a = 1'b1;
        @(negedge clk); go_a = 1'b0;
        chk("t5_load_clears_fault", va, 9'b011110100);
        round(1'b0, 8, 1'b1);
        chk("t5_done", va, 9'b000000110);
        chk("t5_iter", iter_a, 1);
        wait_idle(1'b0);

        // finish coincides with the iteration limit on B.
        go_b = 1'b1;
        @(negedge clk); go_b = 1'b0;
        for (int r = 1; r <= 4; r++) round(1'b1, 1, r == 4);
        chk("t6_done_no_fault", vb, 9'b000000110);
        chk("t6_iter", iter_b, 4);
        wait_idle(1'b1);

        // go held while busy: no restart.
        @(negedge clk);
        snap();
        go_a = 1'b1;
        @(negedge clk); go_a = 1'b0;
        wait_start(1'b0);
        @(negedge clk); go_a = 1'b1;
        repeat (2) @(negedge clk); go_a = 1'b0;
        plu_done = 1'b1; finish = 1'b1;
        @(negedge clk); plu_done = 1'b0;
        @(negedge clk);
        @(negedge clk); finish = 1'b0;
        wait_idle(1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("t7_loads", cnt_load_a - s_load, 1);
        chk("t7_starts", cnt_start_a - s_start, 1);
        chk("t7_dones", cnt_done_a - s_done, 1);
        chk("t7_idle", busy_a, 0);

        // Reset while in WAIT.
        snap();
        go_a = 1'b1;
        @(negedge clk); go_a = 1'b0;
        wait_start(1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t8_async_clear", va, 9'b0);
        chk("t8_async_iter", iter_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("t8_no_done", cnt_done_a - s_done, 0);
        chk("t8_idle", va, 9'b0);
        @(negedge clk);
        go_a = 1'b1;
        @(negedge clk); go_a = 1'b0;
        chk("t8_fresh_load", va, 9'b011110100);
        round(1'b0, 1, 1'b1);
        chk("t8_fresh_done", va, 9'b000000110);
        chk("t8_fresh_iter", iter_a, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
